// File: rtl/kyber_pkg.sv
// Shared constants for the Kyber NTT engine: ring parameters, layer count and butterfly select codes.
package kyber_pkg;

  localparam int KYBER_N     = 256;
  localparam int KYBER_Q     = 3329;
  localparam int NUM_LAYERS  = 7;
  localparam int LOG_N       = 8;
  localparam int COEFF_WIDTH = 12;

  localparam logic [1:0] SEL_NTT    = 2'd0;
  localparam logic [1:0] SEL_INTT   = 2'd1;
  localparam logic [1:0] SEL_BYPASS = 2'd2;

  typedef struct packed {
    logic [LOG_N-1:0] a;
    logic [LOG_N-1:0] b;
  } addr_pair_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address and twiddle index for a given layer / butterfly index / direction.
module ntt_addr_gen
  import kyber_pkg::*;
(
  input  logic [2:0] layer,
  input  logic [6:0] i,
  input  logic       mode,
  output logic [7:0] addr_a,
  output logic [7:0] addr_b,
  output logic [6:0] twid_addr
);

  logic [2:0] sh;
  logic [3:0] sh1;
  logic [7:0] len;
  logic [7:0] g;
  logic [7:0] j;

  always_comb begin
    // sh = log2(len): forward shrinks the span each layer, inverse grows it
    sh     = mode ? (layer + 3'd1) : (3'd7 - layer);
    sh1    = {1'b0, sh} + 4'd1;
    len    = 8'd1 << sh;
    g      = {1'b0, i} >> sh;
    j      = {1'b0, i} & (len - 8'd1);
    addr_a = (g << sh1) | j;
    addr_b = addr_a + len;
    // 7-bit wrap makes 2^7 - 1 - g come out right for the inverse first layer
    twid_addr = mode ? ((7'd1 << (3'd7 - layer)) - 7'd1 - g[6:0])
                     : ((7'd1 << layer) + g[6:0]);
  end

endmodule

// File: rtl/ntt_ctrl.sv
// NTT/INTT sequencer: issues 128 butterflies per layer over 7 layers and replays the
// read addresses as write addresses after the RAM read plus butterfly pipeline latency.
//
// state  | meaning
// IDLE   | waiting for start, outputs quiet, bf_sel = bypass
// ISSUE  | one butterfly read per cycle, i = 0..127
// DRAIN  | 1+BF_LAT cycles letting the layer's writes land
// DONE   | single-cycle completion pulse
module ntt_ctrl
  import kyber_pkg::*;
#(
  parameter int BF_LAT = 2,
  parameter int WIDTH  = COEFF_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] twid_addr,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b,
  output logic [1:0] bf_sel
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int              DW         = $clog2(BF_LAT + 2);
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(BF_LAT);
  localparam logic [2:0]      LAST_LAYER = 3'(NUM_LAYERS - 1);

  logic [1:0]    state;
  logic [2:0]    layer;
  logic [6:0]    i;
  logic [DW-1:0] drain_cnt;
  logic          mode_q;

  logic [7:0] gen_a, gen_b;
  logic [6:0] gen_tw;

  logic [BF_LAT:0]             dly_en;
  addr_pair_t [BF_LAT:0]       dly_ad;

  logic unused_width;
  assign unused_width = (WIDTH != COEFF_WIDTH);

  ntt_addr_gen u_addr_gen (
    .layer     (layer),
    .i         (i),
    .mode      (mode_q),
    .addr_a    (gen_a),
    .addr_b    (gen_b),
    .twid_addr (gen_tw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      layer     <= '0;
      i         <= '0;
      drain_cnt <= '0;
      mode_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_ISSUE;
            layer  <= '0;
            i      <= '0;
            mode_q <= mode;
          end
        end
        S_ISSUE: begin
          i <= i + 7'd1;
          if (i == 7'd127) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            if (layer == LAST_LAYER) begin
              state <= S_DONE;
            end else begin
              state <= S_ISSUE;
              layer <= layer + 3'd1;
            end
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_en     = (state == S_ISSUE);
  assign busy      = (state == S_ISSUE) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign rd_addr_a = rd_en ? gen_a : '0;
  assign rd_addr_b = rd_en ? gen_b : '0;
  assign twid_addr = rd_en ? gen_tw : '0;
  assign bf_sel    = busy ? (mode_q ? SEL_INTT : SEL_NTT) : SEL_BYPASS;

  // Write-back delay line: stage k holds the issue from k+1 cycles ago
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_en <= '0;
      dly_ad <= '0;
    end else begin
      dly_en[0] <= rd_en;
      dly_ad[0] <= '{a: rd_addr_a, b: rd_addr_b};
      for (int k = 1; k <= BF_LAT; k++) begin
        dly_en[k] <= dly_en[k-1];
        dly_ad[k] <= dly_ad[k-1];
      end
    end
  end

  assign wr_en     = dly_en[BF_LAT];
  assign wr_addr_a = dly_ad[BF_LAT].a;
  assign wr_addr_b = dly_ad[BF_LAT].b;

endmodule
